// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel coordinates from hsync_n/vsync_n, measures
// line and frame timing, and qualifies the pixel stream once timing has locked.
module vga_sync_receiver #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_BP        = 49,
    parameter int unsigned H_TOTAL     = 801,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_BP        = 34,
    parameter int unsigned V_TOTAL     = 526,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic [8:0]  pixel_in,
    output logic        pix_valid,
    output logic [8:0]  pix_data,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines
);

    localparam int unsigned HCNT_W  = 11;
    localparam int unsigned VCNT_W  = 10;
    localparam int unsigned MATCH_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam int unsigned TIMEOUT = 2 * H_TOTAL;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic                 h_q, v_q;
    logic [HCNT_W-1:0]    hcnt_q, hcnt_d;
    logic [VCNT_W-1:0]    vcnt_q, vcnt_d;
    logic                 line_err_q, line_err_d;

    logic                 h_rise_c, v_rise_c;
    logic [HCNT_W-1:0]    hcnt_inc_c;
    logic                 line_bad_c, frame_bad_c, timeout_c;
    logic                 frame_ok_c, active_c, lock_fail_c, pix_ok_c, origin_c;
    logic [9:0]           x_c;
    logic [8:0]           y_c;

    // Edge detection and timing checks against the expected line/frame lengths
    always_comb begin
        h_rise_c    = hsync_n & ~h_q;
        v_rise_c    = vsync_n & ~v_q;
        hcnt_inc_c  = hcnt_q + HCNT_W'(1);
        line_bad_c  = h_rise_c && (hcnt_inc_c != HCNT_W'(H_TOTAL));
        frame_bad_c = v_rise_c && (vcnt_q != VCNT_W'(V_TOTAL));
        timeout_c   = (hcnt_q == HCNT_W'(TIMEOUT)) && !h_rise_c;
        frame_ok_c  = (vcnt_q == VCNT_W'(V_TOTAL)) && !line_err_q && !line_bad_c;
        active_c    = (hcnt_q >= HCNT_W'(H_BP)) && (hcnt_q < HCNT_W'(H_BP + H_ACTIVE)) &&
                      (vcnt_q >= VCNT_W'(V_BP)) && (vcnt_q < VCNT_W'(V_BP + V_ACTIVE));
        lock_fail_c = (state_q == ST_LOCKED) && (line_bad_c || frame_bad_c || timeout_c);
        pix_ok_c    = active_c && (state_q == ST_LOCKED) && !lock_fail_c;
        origin_c    = (hcnt_q == HCNT_W'(H_BP)) && (vcnt_q == VCNT_W'(V_BP));
        x_c         = 10'(hcnt_q - HCNT_W'(H_BP));
        y_c         = 9'(vcnt_q - VCNT_W'(V_BP));
    end

    // Horizontal/vertical counters and per-frame line error flag
    always_comb begin
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        line_err_d = line_err_q | line_bad_c;
        if (h_rise_c) begin
            hcnt_d = '0;
        end else if (hcnt_q != '1) begin
            hcnt_d = hcnt_inc_c;
        end
        if (v_rise_c) begin
            vcnt_d     = '0;
            line_err_d = 1'b0;
        end else if (h_rise_c && (vcnt_q != '1)) begin
            vcnt_d = vcnt_q + VCNT_W'(1);
        end
    end

    // Lock FSM next state: timeout wins, then per-state frame qualification
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        if (timeout_c) begin
            state_d = ST_SEARCH;
        end else begin
            unique case (state_q)
                ST_SEARCH: begin
                    if (v_rise_c) begin
                        state_d = ST_MEASURE;
                        match_d = '0;
                    end
                end
                ST_MEASURE: begin
                    if (v_rise_c) begin
                        if (frame_ok_c) begin
                            match_d = match_q + MATCH_W'(1);
                            if ((32'(match_q) + 32'd1) >= LOCK_FRAMES) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (line_bad_c || frame_bad_c) begin
                        state_d = ST_SEARCH;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // State, counters and input sample registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SEARCH;
            match_q    <= '0;
            h_q        <= 1'b1;
            v_q        <= 1'b1;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            line_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            h_q        <= hsync_n;
            v_q        <= vsync_n;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            line_err_q <= line_err_d;
        end
    end

    // Registered outputs; pixel fields hold while no valid pixel is present
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            timing_err  <= 1'b0;
            locked      <= 1'b0;
            pix_data    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            pix_valid   <= pix_ok_c;
            frame_start <= pix_ok_c && origin_c;
            timing_err  <= lock_fail_c;
            locked      <= (state_d == ST_LOCKED);
            if (pix_ok_c) begin
                pix_data <= pixel_in;
                pix_x    <= x_c;
                pix_y    <= y_c;
            end
            if (h_rise_c) begin
                line_len <= hcnt_inc_c;
            end
            if (v_rise_c) begin
                frame_lines <= vcnt_q;
            end
        end
    end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink side of the 640x480 VGA pixel interface: consumes hsync_n, vsync_n and the 9-bit pixel bus, recovers pixel coordinates, and emits a qualified pixel stream.
- Measures line period and frame height, and declares lock only after consecutive frames match the expected timing.
- Sits on the pixel clock domain; used for loopback checking of the timing generator and as the front end of frame capture.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_BP, 49, cycles from first hsync_n=1 sample after sync pulse to first active pixel
- H_TOTAL, 801, expected cycles between successive hsync_n rising edges
- V_ACTIVE, 480, active lines per frame
- V_BP, 34, hsync_n rising edges after vsync_n rising edge before active line 0 begins
- V_TOTAL, 526, expected hsync_n rising edges between successive vsync_n rising edges
- LOCK_FRAMES, 2, consecutive matching frames required to lock

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous, active-high reset
- hsync_n  in  1  horizontal sync, active low
- vsync_n  in  1  vertical sync, active low
- pixel_in  in  9  incoming pixel colour
- pix_valid  out  1  pix_data/pix_x/pix_y hold an active, locked pixel
- pix_data  out  9  captured pixel
- pix_x  out  10  column 0..H_ACTIVE-1
- pix_y  out  9  row 0..V_ACTIVE-1
- frame_start  out  1  one-cycle pulse coincident with pix_valid for pixel (0,0)
- locked  out  1  timing lock status
- timing_err  out  1  one-cycle pulse on a timing mismatch or timeout
- line_len  out  11  last measured hsync rise-to-rise period in cycles
- frame_lines  out  10  last measured vsync rise-to-rise count in lines

Behaviour:
- Inputs are sampled into a one-stage register (h_q, v_q).
- A rise event is a cycle where the input is 1 and its q value is 0. No deglitching.
- Horizontal counter hcnt (11 b):
  - Cleared to 0 on the hsync rise cycle; +1 otherwise; saturates at 2047.
  - At each hsync rise, line_len <= hcnt+1 (rise-to-rise period).
- Line counter vcnt (10 b):
  - Cleared to 0 on a vsync rise; +1 on each hsync rise; saturates at 1023.
  - If both rise in the same cycle, vcnt <= 0.
  - At each vsync rise, frame_lines <= vcnt.
- Active region: x = hcnt - H_BP, y = vcnt - V_BP. Active when H_BP <= hcnt < H_BP+H_ACTIVE and V_BP <= vcnt < V_BP+V_ACTIVE.
- Output latency is 1 cycle: pixel_in sampled in cycle c appears on pix_data with pix_x/pix_y in cycle c+1.
- pix_valid = active(c) AND state==LOCKED.
- frame_start is asserted when pix_valid=1 with x=0 and y=0.
- When pix_valid=0, pix_data/pix_x/pix_y hold their last values.
- FSM:
  - SEARCH: wait for a vsync rise -> MEASURE, match_cnt=0.
  - MEASURE: at each vsync rise, frame_ok = (vcnt==V_TOTAL) and no line error since the previous vsync rise. If ok, match_cnt+1; on reaching LOCK_FRAMES -> LOCKED. If not ok, match_cnt=0 and stay.
  - LOCKED: locked=1.
    - Any hsync rise with hcnt+1 != H_TOTAL, or any vsync rise with vcnt != V_TOTAL, pulses timing_err and goes to SEARCH.
    - The pixel in the failing cycle is not marked valid.
  - Timeout in any state: hcnt reaches 2*H_TOTAL without an hsync rise -> pulse timing_err if previously locked, go to SEARCH.
  - A line error in MEASURE does not pulse timing_err; timing_err fires only when leaving LOCKED.
- Reset values:
  - state=SEARCH; hcnt, vcnt, match_cnt = 0; h_q = v_q = 1.
  - pix_valid, frame_start, timing_err, locked = 0.
  - pix_data, pix_x, pix_y, line_len, frame_lines = 0.
- Reset asserted mid-frame returns to SEARCH next cycle; a fresh lock needs LOCK_FRAMES full frames after the next vsync rise.

Test Plan:
- Reset, then drive the compliant generator timing (801-cycle lines, 526-line frames, hsync low for countX 656..751, vsync low for lines 490..491, pixel=x[8:0]^y[8:0]):
  - locked rises exactly at the 3rd vsync rise after reset.
  - line_len=801, frame_lines=526.
  - The first valid frame yields 307200 pix_valid cycles with pix_x/pix_y matching, pix_data=x^y.
  - frame_start pulses once per frame.
- In LOCKED, lengthen one line to 802 cycles -> timing_err pulses once at that hsync rise, locked=0 next cycle, and no pix_valid until relock two frames later.
- Stop toggling hsync_n (held 1) while locked -> timing_err pulses after 1602 cycles of no rise; state SEARCH; pix_valid stays 0.
- Frames of 525 lines -> never locks, timing_err never pulses, frame_lines=525.
- Assert rst for 1 cycle mid-line while locked -> next cycle locked=0 and all outputs at reset values; relock after 2 matching frames.
- Drive hsync and vsync rising in the same cycle -> vcnt=0, frame_lines captures the pre-clear count.
